// File: rtl/mux_scan_ctrl.sv
// Sequencer for a 4:1 select mux: steps the select lines through a..d with a
// programmable dwell per channel and publishes a 4-bit snapshot per sweep.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for start; select parked on channel a, busy low
// ST_SCAN   | sweeping channels; dwell counter runs down, y captured at zero
module mux_scan_ctrl #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          cont,
    input  logic [DW-1:0] dwell,
    input  logic          y,
    output logic          s1,
    output logic          s2,
    output logic [3:0]    data,
    output logic          valid,
    output logic          busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      sel_q, sel_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [2:0]      shadow_q, shadow_d;
    logic [3:0]      data_q, data_d;
    logic            valid_q, valid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= 2'd0;
            cnt_q    <= '0;
            dwell_q  <= '0;
            shadow_q <= 3'd0;
            data_q   <= 4'd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            dwell_q  <= dwell_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        dwell_d  = dwell_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        valid_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sel_d = 2'd0;
                if (start) begin
                    state_d  = ST_SCAN;
                    cnt_d    = dwell;
                    dwell_d  = dwell;
                    shadow_d = 3'd0;
                end
            end

            ST_SCAN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    sel_d   = 2'd0;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DW'(1);
                end else begin
                    // Channel d is never stored; it goes straight into the snapshot.
                    case (sel_q)
                        2'd0: shadow_d[0] = y;
                        2'd1: shadow_d[1] = y;
                        2'd2: shadow_d[2] = y;
                        default: begin
                            data_d  = {y, shadow_q};
                            valid_d = 1'b1;
                        end
                    endcase

                    if (sel_q != 2'd3) begin
                        sel_d = sel_q + 2'd1;
                        cnt_d = dwell_q;
                    end else begin
                        sel_d = 2'd0;
                        if (cont) begin
                            cnt_d    = dwell;
                            dwell_d  = dwell;
                            shadow_d = 3'd0;
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                sel_d   = 2'd0;
            end
        endcase
    end

    always_comb begin
        s1    = sel_q[1];
        s2    = sel_q[0];
        data  = data_q;
        valid = valid_q;
        busy  = (state_q == ST_SCAN);
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: a cycle-level sweep model driven by elapsed
// time since start, checked every cycle, plus literal expectations per scenario.
module tb_mux_scan_ctrl;

    localparam int DW = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic          stop;
    logic          cont;
    logic [DW-1:0] dwell;
    logic          y;
    logic          s1;
    logic          s2;
    logic [3:0]    data;
    logic          valid;
    logic          busy;

    logic [3:0]    ch;   // ch[0]=a .. ch[3]=d
    assign y = ch[{s1, s2}];

    int errors = 0;
    int checks = 0;

    mux_scan_ctrl #(.DW(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .cont  (cont),
        .dwell (dwell),
        .y     (y),
        .s1    (s1),
        .s2    (s2),
        .data  (data),
        .valid (valid),
        .busy  (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: a sweep is "t cycles since start"; channel index is t/(D+1),
    // a capture happens whenever t reaches a multiple of D+1.
    bit       m_ok = 0;
    bit       m_busy;
    int       m_t;
    int       m_d;
    bit [3:0] m_snap;
    bit [3:0] m_data;
    bit       m_valid;

    always @(posedge clk) begin
        int per;
        int k;
        if (rst) begin
            m_ok = 1; m_busy = 0; m_t = 0; m_d = 0;
            m_snap = 0; m_data = 0; m_valid = 0;
        end else if (m_ok) begin
            m_valid = 0;
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1; m_t = 0; m_d = int'(dwell); m_snap = 0;
                end
            end else if (stop) begin
                m_busy = 0; m_t = 0;
            end else begin
                per = m_d + 1;
                k = m_t / per;
                m_t = m_t + 1;
                if (m_t % per == 0) begin
                    m_snap[k] = ch[k];
                    if (k == 3) begin
                        m_data = m_snap;
                        m_valid = 1;
                        m_t = 0;
                        if (cont) begin
                            m_d = int'(dwell); m_snap = 0;
                        end else begin
                            m_busy = 0;
                        end
                    end
                end
            end
        end
    end

    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        int exp_sel;
        if (m_ok) begin
            exp_sel = m_busy ? m_t / (m_d + 1) : 0;
            chk("model_sel",   {30'd0, s1, s2}, exp_sel);
            chk("model_busy",  busy,  m_busy);
            chk("model_valid", valid, m_valid);
            chk("model_data",  data,  m_data);
            if (prev_valid && valid) chk("valid_back_to_back", valid, 1'b0);
            prev_valid = valid;
        end
    end

    initial begin
        int n;
        int vcount;
        bit dexp;

        rst = 1'b1; start = 1'($urandom); stop = 1'($urandom); cont = 1'($urandom);
        dwell = DW'($urandom); ch = 4'($urandom);
        tick(); tick();
        chk("reset_data",  data,  4'b0000);
        chk("reset_valid", valid, 1'b0);
        chk("reset_busy",  busy,  1'b0);
        chk("reset_sel",   {s1, s2}, 2'b00);
        rst = 1'b0; start = 0; stop = 0; cont = 0; dwell = 0; ch = 0;
        tick();

        // One-shot, dwell 0, a=1 b=0 c=1 d=1
        ch = 4'b1101; dwell = 0; start = 1;
        tick(); start = 0;
        chk("os_sel0", {s1, s2}, 2'b00);
        chk("os_busy", busy, 1'b1);
        tick(); chk("os_sel1", {s1, s2}, 2'b01);
        tick(); chk("os_sel2", {s1, s2}, 2'b10);
        tick(); chk("os_sel3", {s1, s2}, 2'b11);
        tick();
        chk("os_valid", valid, 1'b1);
        chk("os_data",  data,  4'b1101);
        chk("os_busy_end", busy, 1'b0);
        tick();
        chk("os_valid_drop", valid, 1'b0);

        // One-shot, dwell 3, a=0 b=1 c=0 d=0
        ch = 4'b0010; dwell = 3; start = 1;
        tick(); start = 0; dwell = 0;
        vcount = 0;
        for (int t = 0; t < 16; t++) begin
            chk("d3_sel_hold", {30'd0, s1, s2}, t / 4);
            if (valid) vcount++;
            tick();
        end
        if (valid) vcount++;
        chk("d3_data", data, 4'b0010);
        for (int t = 0; t < 3; t++) begin
            tick();
            if (valid) vcount++;
        end
        chk("d3_valid_count", vcount, 1);

        // Continuous, dwell 0, d toggled between sweeps
        ch = 4'b1101; dwell = 0; cont = 1; start = 1;
        tick(); start = 0;
        dexp = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            for (int j = 0; j < 3; j++) begin
                tick();
                chk("cont_valid_gap", valid, 1'b0);
            end
            tick();
            chk("cont_valid", valid, 1'b1);
            chk("cont_d_bit", data[3], dexp);
            ch[3] = ~ch[3];
            dexp = ~dexp;
            if (k == 2) cont = 0;
        end
        chk("cont_idle", busy, 1'b0);
        tick();
        chk("cont_stays_idle", busy, 1'b0);

        // Abort with prior data 1101; start during the sweep is ignored
        chk("abort_prior", data, 4'b1101);
        ch = 4'b0000; dwell = 2; start = 1;
        tick(); start = 0;
        tick(); start = 1;
        tick(); start = 0;
        chk("abort_sel_n2", {s1, s2}, 2'b00);
        tick();
        chk("abort_no_restart", {s1, s2}, 2'b01);
        tick(); stop = 1;
        tick(); stop = 0;
        chk("abort_busy",  busy,  1'b0);
        chk("abort_data",  data,  4'b1101);
        chk("abort_valid", valid, 1'b0);
        tick(); tick();
        chk("abort_quiet", valid, 1'b0);

        // Reset mid-sweep, then a clean sweep from channel a
        ch = 4'b0110; dwell = 1; start = 1;
        tick(); start = 0;
        tick(); tick(); rst = 1;
        tick(); rst = 0;
        chk("mrst_data",  data,  4'b0000);
        chk("mrst_valid", valid, 1'b0);
        chk("mrst_busy",  busy,  1'b0);
        chk("mrst_sel",   {s1, s2}, 2'b00);
        tick();
        ch = 4'b1010; dwell = 0; start = 1;
        tick(); start = 0;
        chk("mrst_first_sel", {s1, s2}, 2'b00);
        tick(); chk("mrst_second_sel", {s1, s2}, 2'b01);
        tick(); tick(); tick();
        chk("mrst_valid_after", valid, 1'b1);
        chk("mrst_data_after",  data,  4'b1010);

        // Maximum dwell: 64-cycle sweep
        tick();
        ch = 4'b1011; dwell = 4'hF; start = 1;
        tick(); start = 0; dwell = 0;
        n = 0;
        while (!valid && n < 200) begin
            tick();
            n++;
        end
        chk("maxdw_latency", n, 64);
        chk("maxdw_data", data, 4'b1011);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
